// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared ALU op encodings and reservation-station defaults
package alu_rs_pkg;
    localparam int DATA_W        = 32;
    localparam int RS_SIZE_DEF   = 8;
    localparam int TAG_WIDTH_DEF = 4;
    localparam int OP_WIDTH_DEF  = 4;
    typedef enum logic [3:0] {
        OP_ADD, OP_MINUS, OP_LESS, OP_LESS_U, OP_XOR,
        OP_OR, OP_AND, OP_LSHIFT, OP_RSHIFT, OP_RSHIFT_A
    } op_e;
endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-index priority encoder over a request vector
module rs_select import alu_rs_pkg::*; #(
    parameter int N = RS_SIZE_DEF
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
    assign found = |req;
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB snoop, lowest-index issue and registered broadcast
module alu_rs import alu_rs_pkg::*; #(
    parameter int RS_SIZE   = RS_SIZE_DEF,
    parameter int TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int OP_WIDTH  = OP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    input  logic [OP_WIDTH-1:0]  dispatch_op,
    input  logic [DATA_W-1:0]    dispatch_vj,
    input  logic                 dispatch_qj_busy,
    input  logic [TAG_WIDTH-1:0] dispatch_qj,
    input  logic [DATA_W-1:0]    dispatch_vk,
    input  logic                 dispatch_qk_busy,
    input  logic [TAG_WIDTH-1:0] dispatch_qk,
    input  logic [TAG_WIDTH-1:0] dispatch_dest,
    output logic                 rs_full,
    input  logic                 cdb_in_valid,
    input  logic [TAG_WIDTH-1:0] cdb_in_tag,
    input  logic [DATA_W-1:0]    cdb_in_value,
    output logic                 alu_ready,
    output logic [DATA_W-1:0]    alu_lv,
    output logic [DATA_W-1:0]    alu_rv,
    output logic [OP_WIDTH-1:0]  alu_op,
    input  logic                 alu_success,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 cdb_out_valid,
    output logic [TAG_WIDTH-1:0] cdb_out_tag,
    output logic [DATA_W-1:0]    cdb_out_value
);
    localparam int IW = $clog2(RS_SIZE);
    logic [RS_SIZE-1:0]   busy, qj_busy, qk_busy, ready, nqj_busy, nqk_busy;
    logic [OP_WIDTH-1:0]  op   [RS_SIZE];
    logic [DATA_W-1:0]    vj   [RS_SIZE];
    logic [DATA_W-1:0]    vk   [RS_SIZE];
    logic [DATA_W-1:0]    nvj  [RS_SIZE];
    logic [DATA_W-1:0]    nvk  [RS_SIZE];
    logic [TAG_WIDTH-1:0] qj   [RS_SIZE];
    logic [TAG_WIDTH-1:0] qk   [RS_SIZE];
    logic [TAG_WIDTH-1:0] dest [RS_SIZE];
    logic [TAG_WIDTH-1:0] issue_tag;
    logic [DATA_W-1:0]    d_vj, d_vk;
    logic                 d_qj_busy, d_qk_busy;
    logic                 free_found, iss_found, advance, dispatch_go;
    logic [IW-1:0]        free_idx, iss_idx;

    // cdb_out wins when both buses carry the same tag
    function automatic logic [DATA_W:0] snoop(input logic pend, input logic [TAG_WIDTH-1:0] tag,
                                               input logic [DATA_W-1:0] val);
        snoop = !pend ? {1'b0, val} :
                (cdb_out_valid && cdb_out_tag == tag) ? {1'b0, cdb_out_value} :
                (cdb_in_valid && cdb_in_tag == tag) ? {1'b0, cdb_in_value} : {1'b1, val};
    endfunction

    always_comb begin
        nqj_busy = '0;
        nqk_busy = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            {nqj_busy[i], nvj[i]} = snoop(qj_busy[i], qj[i], vj[i]);
            {nqk_busy[i], nvk[i]} = snoop(qk_busy[i], qk[i], vk[i]);
        end
        {d_qj_busy, d_vj} = snoop(dispatch_qj_busy, dispatch_qj, dispatch_vj);
        {d_qk_busy, d_vk} = snoop(dispatch_qk_busy, dispatch_qk, dispatch_vk);
    end

    assign ready       = busy & ~qj_busy & ~qk_busy;
    assign rs_full     = &busy;
    assign advance     = rdy && !flush;
    assign dispatch_go = advance && dispatch_valid && free_found;

    rs_select #(.N(RS_SIZE)) u_free  (.req(~busy), .found(free_found), .idx(free_idx));
    rs_select #(.N(RS_SIZE)) u_issue (.req(ready), .found(iss_found),  .idx(iss_idx));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= '0;
            alu_ready     <= 1'b0;
            alu_lv        <= '0;
            alu_rv        <= '0;
            alu_op        <= '0;
            issue_tag     <= '0;
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_value <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy          <= '0;
                alu_ready     <= 1'b0;
                cdb_out_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++)
                    busy[i] <= (busy[i] && !(iss_found && iss_idx == IW'(i))) ||
                               (dispatch_go && free_idx == IW'(i));
                alu_ready <= iss_found;
                if (iss_found) begin
                    alu_lv    <= vj[iss_idx];
                    alu_rv    <= vk[iss_idx];
                    alu_op    <= op[iss_idx];
                    issue_tag <= dest[iss_idx];
                end
                cdb_out_valid <= alu_ready && alu_success;
                cdb_out_value <= alu_result;
                cdb_out_tag   <= issue_tag;
            end
        end
    end

    // Entry payload needs no reset: busy alone decides whether it means anything
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (dispatch_go && free_idx == IW'(i)) begin
                    op[i]      <= dispatch_op;
                    vj[i]      <= d_vj;
                    vk[i]      <= d_vk;
                    qj_busy[i] <= d_qj_busy;
                    qk_busy[i] <= d_qk_busy;
                    qj[i]      <= dispatch_qj;
                    qk[i]      <= dispatch_qk;
                    dest[i]    <= dispatch_dest;
                end else begin
                    vj[i]      <= nvj[i];
                    vk[i]      <= nvk[i];
                    qj_busy[i] <= nqj_busy[i];
                    qk_busy[i] <= nqk_busy[i];
                end
            end
        end
    end
endmodule
